// File: rtl/sram_controller_if.sv
// ============================================================================
// Module   : sram_controller_if
// Purpose  : Pipeline-side memory request/response bundle for sram_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module   : sram_controller
// Purpose  : Splits 32-bit pipeline loads/stores into two timed 16-bit SRAM
//            half-accesses, freezing the pipeline via ready meanwhile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  wire               clk,
  input  wire               rst,
  sram_controller_if.slave  bus,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_write;
  logic [16:0]        r_waddr;
  logic [15:0]        r_wdata_hi;
  logic [31:0]        r_read_data;
  logic [17:0]        r_sram_addr;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [15:0]        r_dq_out;

  logic               w_req;
  logic               w_last;
  logic [31:0]        w_offset;
  logic [16:0]        w_waddr;
  logic               w_unused;

  assign w_req    = bus.wr_en | bus.rd_en;
  assign w_last   = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_offset = bus.address - DATA_BASE;
  // Word address bits above SRAM_ADDR's reach are dropped without a range check.
  assign w_waddr  = w_offset[18:2];
  assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_waddr     <= '0;
      r_wdata_hi  <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // wr_en wins when both requests are raised together.
            r_is_write  <= bus.wr_en;
            r_waddr     <= w_waddr;
            r_wdata_hi  <= bus.write_data[31:16];
            r_cnt       <= '0;
            r_sram_addr <= {w_waddr, 1'b0};
            r_we_n      <= ~bus.wr_en;
            r_dq_oe     <= bus.wr_en;
            r_dq_out    <= bus.write_data[15:0];
            r_state     <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_last) begin
            if (!r_is_write) r_read_data[15:0] <= SRAM_DQ;
            r_cnt       <= '0;
            r_sram_addr <= {r_waddr, 1'b1};
            r_dq_out    <= r_wdata_hi;
            r_state     <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_last) begin
            if (!r_is_write) r_read_data[31:16] <= SRAM_DQ;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign bus.read_data = r_read_data;

  assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'bz;
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  // Output enable stays asserted during writes; the SRAM gives WE_N precedence.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Directed self-checking bench for sram_controller with an SRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_controller;

  logic        clk;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  int errors = 0;
  int checks = 0;

  sram_controller_if bus_if();

  sram_controller #(.WAIT_CYCLES(5), .DATA_BASE(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus whenever not being written (OE_N tied low).
  logic [15:0] mem [0:63];
  logic        mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[5:0]] <= SRAM_DQ;
    end
  end
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[5:0]] : 16'bz;

  // Expected {ready, WE_N, SRAM_ADDR, DQ} at cycle c of a transaction whose
  // request is first seen in IDLE at cycle 0 (idle address 0 reads mem[0]=0).
  function automatic logic [35:0] exp_vec(input int c, input logic [16:0] w,
                                          input logic [15:0] lo, input logic [15:0] hi,
                                          input logic wr);
    logic        e_ready;
    logic        e_we_n;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    e_ready = (c == 11);
    e_we_n  = !(wr && c >= 1 && c <= 10);
    e_addr  = 18'd0;
    e_dq    = 16'h0000;
    if (c >= 1 && c <= 5) begin
      e_addr = {w, 1'b0};
      e_dq   = lo;
    end else if (c >= 6 && c <= 10) begin
      e_addr = {w, 1'b1};
      e_dq   = hi;
    end
    return {e_ready, e_we_n, e_addr, e_dq};
  endfunction

  task automatic drive_req(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] d);
    @(posedge clk);
    #1;
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.address    = a;
    bus_if.write_data = d;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_clear = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.address = 32'd0;
    bus_if.write_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 mem_clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ} !== {1'b1, 1'b1, 18'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_outputs: got ready/we_n/addr/dq=%b/%b/%h/%h need 1/1/0/0",
               bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ);
    end
    checks++;
    if (bus_if.read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_read_data: got %h need 00000000", bus_if.read_data);
    end
    checks++;
    if ({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl_pins: got %b need 0000",
               {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N});
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_if.ready, SRAM_WE_N, SRAM_DQ} !== {1'b1, 1'b1, 16'h0000}) begin
        errors++;
        $display("FAIL idle_c%0d: got ready/we_n/dq=%b/%b/%h need 1/1/0000",
                 c, bus_if.ready, SRAM_WE_N, SRAM_DQ);
      end
    end
  endtask

  // Store of data to address a; requests drop after cycle 1 and must not matter.
  task automatic test_write(input string tag, input logic rd_too, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] keep_rd);
    logic [16:0] w;
    logic [35:0] got;
    logic [35:0] exp;
    w = 17'((a - 32'd1024) >> 2);
    drive_req(1'b1, rd_too, a, d);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      got = {bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ};
      exp = exp_vec(c, w, d[15:0], d[31:16], 1'b1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_c%0d: got rdy/we_n/addr/dq=%h need %h", tag, c, got, exp);
      end
      if (c == 1) begin
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        bus_if.write_data = 32'h0;
      end
    end
    checks++;
    if (bus_if.read_data !== keep_rd) begin
      errors++;
      $display("FAIL %s_read_data_kept: got %h need %h", tag, bus_if.read_data, keep_rd);
    end
  endtask

  task automatic test_read(input string tag, input logic [31:0] a, input logic [15:0] lo,
                           input logic [15:0] hi);
    logic [16:0] w;
    logic [35:0] got;
    logic [35:0] exp;
    w = 17'((a - 32'd1024) >> 2);
    drive_req(1'b0, 1'b1, a, 32'hFFFF_FFFF);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      got = {bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ};
      exp = exp_vec(c, w, lo, hi, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_c%0d: got rdy/we_n/addr/dq=%h need %h", tag, c, got, exp);
      end
      if (c == 1) begin
        bus_if.rd_en = 1'b0;
        bus_if.address = 32'd0;
      end
    end
    checks++;
    if (bus_if.read_data !== {hi, lo}) begin
      errors++;
      $display("FAIL %s_data: got %h need %h", tag, bus_if.read_data, {hi, lo});
    end
  endtask

  task automatic test_back_to_back;
    logic [35:0] got;
    logic [35:0] exp;
    drive_req(1'b0, 1'b1, 32'd1032, 32'h0);
    for (int c = 0; c <= 23; c++) begin
      @(negedge clk);
      got = {bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ};
      if (c <= 11) exp = exp_vec(c, 17'd2, 16'hBEEF, 16'hDEAD, 1'b0);
      else         exp = exp_vec(c - 12, 17'd4, 16'h5678, 16'h1234, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_c%0d: got rdy/we_n/addr/dq=%h need %h", c, got, exp);
      end
      if (c == 11 || c == 23) begin
        checks++;
        if (bus_if.read_data !== ((c == 11) ? 32'hDEADBEEF : 32'h12345678)) begin
          errors++;
          $display("FAIL b2b_data_c%0d: got %h need %h", c, bus_if.read_data,
                   (c == 11) ? 32'hDEADBEEF : 32'h12345678);
        end
      end
      if (c == 3)  bus_if.address = 32'd1056;
      if (c == 11) bus_if.address = 32'd1040;
      if (c == 23) bus_if.rd_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    drive_req(1'b1, 1'b0, 32'd1048, 32'hCAFEF00D);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) bus_if.wr_en = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ} !== {1'b1, 1'b1, 18'd0, 16'h0000}) begin
      errors++;
      $display("FAIL rstmid_outputs: got ready/we_n/addr/dq=%b/%b/%h/%h need 1/1/0/0",
               bus_if.ready, SRAM_WE_N, SRAM_ADDR, SRAM_DQ);
    end
    checks++;
    if (bus_if.read_data !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_read_data: got %h need 00000000", bus_if.read_data);
    end
    checks++;
    if ({mem[13], mem[12]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rstmid_sram_half: got %h need cafef00d", {mem[13], mem[12]});
    end
    rst = 1'b1;
    test_read("rstmid_read", 32'd1032, 16'hBEEF, 16'hDEAD);
  endtask

  initial begin
    rst = 1'b0;
    mem_clear = 1'b1;
    test_reset();
    test_idle();
    test_write("write", 1'b0, 32'd1032, 32'hDEADBEEF, 32'd0);
    test_read("read", 32'd1032, 16'hBEEF, 16'hDEAD);
    test_write("simul", 1'b1, 32'd1040, 32'h12345678, 32'hDEADBEEF);
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
